scm_write_arbiter: RTL and testbench
====================================

Name: scm_write_arbiter

Overview:
- Shares the single write port of a latch-based 1W/multi-read SCM register file among N_WRITE requesters, using round-robin arbitration.
- Tracks the one in-flight write. The latch becomes transparent only in the cycle after the grant, so the block protects read ports from read-after-write hazards on that address.
- Sits between core/accelerator write sources and the SCM macro. It drives the SCM's write-enable/address/data and read-enable/address directly.

Parameters:
- N_WRITE, 4, number of write requesters (>=1)
- N_READ, 2, number of read ports (>=1)
- ADDR_WIDTH, 5, SCM address width; NUM_WORDS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wreq_i  in  N_WRITE  write request per requester; held until granted
- waddr_i  in  N_WRITE x ADDR_WIDTH  write address per requester
- wdata_i  in  N_WRITE x DATA_WIDTH  write data per requester
- wgnt_o  out  N_WRITE  one-hot write grant; the transfer completes in the cycle wreq&wgnt
- rreq_i  in  N_READ  read request per port
- raddr_i  in  N_READ x ADDR_WIDTH  read address per port
- rgnt_o  out  N_READ  read accepted; rdata_o valid in the same cycle
- rdata_o  out  N_READ x DATA_WIDTH  read data
- scm_we_o  out  1  SCM WriteEnable
- scm_waddr_o  out  ADDR_WIDTH  SCM write address
- scm_wdata_o  out  DATA_WIDTH  SCM WriteData
- scm_re_o  out  N_READ  SCM ReadEnable
- scm_raddr_o  out  N_READ x ADDR_WIDTH  SCM read addresses
- scm_rdata_i  in  N_READ x DATA_WIDTH  SCM read data (combinational)
- busy_o  out  1  in-flight write pending

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - rr_ptr=0, infl_valid=0, infl_addr=0, infl_data=0.
  - While rst_n=0, wgnt_o, rgnt_o, scm_we_o, scm_re_o and busy_o are forced to 0.
- Write arbitration (combinational grant):
  - Grant the first requester with wreq_i=1, searching from rr_ptr upward with wrap N_WRITE-1 -> 0.
  - At most one wgnt_o bit is set.
  - scm_we_o = |wgnt_o; scm_waddr_o/scm_wdata_o = the granted requester's waddr_i/wdata_i, else 0.
  - On a grant to index g at the clock edge: rr_ptr <= (g+1) mod N_WRITE. With no grant, rr_ptr holds.
  - No request -> no grant; rr_ptr unchanged.
- In-flight tracking (grant in cycle T):
  - At the edge ending T: infl_valid<=1, infl_addr<=granted address, infl_data<=granted data.
  - infl_valid stays 1 for exactly cycle T+1, then clears unless a new grant occurs in T+1.
  - busy_o = infl_valid.
  - Back-to-back writes, including to the same address, are allowed every cycle; the write port always has throughput 1/cycle.
- Read path:
  - scm_re_o[i] = rreq_i[i] & rgnt_o[i]; scm_raddr_o[i] = raddr_i[i].
  - Hazard[i] = rreq_i[i] & infl_valid & (raddr_i[i]==infl_addr).
  - Non-hazard read: rgnt_o[i]=1; rdata_o[i]=scm_rdata_i[i] in the same cycle (zero latency).
  - A read in the same cycle as a write to the same address (cycle T) returns the old value, i.e. read-before-write.
  - Hazard handling is defined under Optional Feature.
  - With rreq_i[i]=0: rgnt_o[i]=0; rdata_o[i]=0.
- Reset asserted mid-operation: the in-flight record is discarded immediately. Completion of a write the SCM has already sampled is the SCM's responsibility.
- Requesters must hold wreq_i, waddr_i and wdata_i stable until granted. Dropping a request before its grant is legal and has no side effect.

Optional Feature:
- Macro: SCM_WARB_BYPASS_EN
- Defined: a hazard read is granted (rgnt_o[i]=1) and rdata_o[i]=infl_data; scm_re_o[i]=0 for that port. Reads never stall.
- Undefined: a hazard read stalls (rgnt_o[i]=0, scm_re_o[i]=0) for the hazard cycle. It is granted in the next cycle with SCM data, provided no new same-address write is in flight.

Test Plan:
- Reset then idle -> all grants 0, scm_we_o=0, busy_o=0, rr_ptr=0.
- wreq_i=4'b1111 held for 4 cycles -> grants 0,1,2,3 in order; the 5th cycle grants 0 again; scm_we_o=1 every cycle.
- wreq_i=4'b1010 with rr_ptr=2 -> grant 3, then 1, then 3; requesters 0 and 2 are never granted.
- Write addr 5 data 0xA5A5A5A5 in T; read addr 5 in T+1:
  - Bypass undefined: rgnt_o=0 in T+1; rgnt=1 in T+2 with rdata=0xA5A5A5A5.
  - Bypass defined: rgnt_o=1 in T+1 with rdata=0xA5A5A5A5.
- Write addr 5 in T; read addr 6 in T+1 -> rgnt_o=1 with SCM data; a read of addr 5 in T returns the old value.
- Assert rst_n low in T+1 after a grant in T -> busy_o=0 and all grants 0 immediately; after release rr_ptr=0 and a read of addr 5 is not stalled.

Source files
------------

// File: rtl/scm_write_arbiter_if.sv
// Bundle of requester-side and SCM-side signals around scm_write_arbiter.
// slave: the arbiter's view; master: the surrounding environment's view.
interface scm_write_arbiter_if #(
  parameter int N_WRITE    = 4,
  parameter int N_READ     = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [N_WRITE-1:0]                 wreq_i;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [N_WRITE-1:0]                 wgnt_o;
  logic [N_READ-1:0]                  rreq_i;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]  raddr_i;
  logic [N_READ-1:0]                  rgnt_o;
  logic [N_READ-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic                               scm_we_o;
  logic [ADDR_WIDTH-1:0]              scm_waddr_o;
  logic [DATA_WIDTH-1:0]              scm_wdata_o;
  logic [N_READ-1:0]                  scm_re_o;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]  scm_raddr_o;
  logic [N_READ-1:0][DATA_WIDTH-1:0]  scm_rdata_i;
  logic                               busy_o;

  modport slave (
    input  wreq_i, waddr_i, wdata_i, rreq_i, raddr_i, scm_rdata_i,
    output wgnt_o, rgnt_o, rdata_o, scm_we_o, scm_waddr_o, scm_wdata_o,
           scm_re_o, scm_raddr_o, busy_o
  );

  modport master (
    output wreq_i, waddr_i, wdata_i, rreq_i, raddr_i, scm_rdata_i,
    input  wgnt_o, rgnt_o, rdata_o, scm_we_o, scm_waddr_o, scm_wdata_o,
           scm_re_o, scm_raddr_o, busy_o
  );
endinterface

// File: rtl/scm_write_arbiter.sv
// Round-robin arbiter for the single write port of a latch-based SCM, with
// read-after-write hazard protection for the address whose latch is still
// transparent in the cycle after its grant.
// Optional macro SCM_WARB_BYPASS_EN: hazard reads are served from the
// in-flight record instead of stalling for one cycle.
module scm_write_arbiter #(
  parameter int N_WRITE    = 4,
  parameter int N_READ     = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  scm_write_arbiter_if.slave  bus
);
  localparam int PTR_W = (N_WRITE > 1) ? $clog2(N_WRITE) : 1;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  infl_valid_q, infl_valid_d;
  logic [ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;
  logic [DATA_WIDTH-1:0] infl_data_q, infl_data_d;

  logic                  gnt_found;
  logic [PTR_W-1:0]      gnt_idx;
  logic [N_WRITE-1:0]    gnt_vec;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  logic [N_READ-1:0]                 rgnt;
  logic [N_READ-1:0]                 re;
  logic [N_READ-1:0][DATA_WIDTH-1:0] rdata;

  // Requester index at a given distance above the round-robin pointer.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % 32'(N_WRITE);
    return sum[PTR_W-1:0];
  endfunction

  // Find the first active requester starting at the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < 32'(N_WRITE); k++) begin
      if (!gnt_found && bus.wreq_i[wrap_idx(rr_ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

  // Drive the one-hot grant and the SCM write port; silent while in reset.
  always_comb begin
    gnt_vec = '0;
    we      = gnt_found & rst_n;
    waddr   = '0;
    wdata   = '0;
    if (we) begin
      gnt_vec[gnt_idx] = 1'b1;
      waddr            = bus.waddr_i[gnt_idx];
      wdata            = bus.wdata_i[gnt_idx];
    end
  end

  // Next pointer and in-flight record: a grant opens a one-cycle hazard window.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    infl_valid_d = we;
    infl_addr_d  = infl_addr_q;
    infl_data_d  = infl_data_q;
    if (we) begin
      rr_ptr_d    = (gnt_idx == PTR_W'(N_WRITE - 1)) ? '0 : gnt_idx + 1'b1;
      infl_addr_d = waddr;
      infl_data_d = wdata;
    end
  end

  // State registers; reset discards the in-flight record immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      infl_valid_q <= 1'b0;
      infl_addr_q  <= '0;
      infl_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      infl_valid_q <= infl_valid_d;
      infl_addr_q  <= infl_addr_d;
      infl_data_q  <= infl_data_d;
    end
  end

  // Per-port read path: the in-flight address is unsafe to read from the SCM.
  for (genvar gi = 0; gi < N_READ; gi++) begin : g_read
    logic hazard;
    assign hazard = bus.rreq_i[gi] & infl_valid_q &
                    (bus.raddr_i[gi] == infl_addr_q);
`ifdef SCM_WARB_BYPASS_EN
    assign rgnt[gi]  = rst_n & bus.rreq_i[gi];
    assign re[gi]    = rst_n & bus.rreq_i[gi] & ~hazard;
    assign rdata[gi] = !rgnt[gi] ? '0 :
                       (hazard ? infl_data_q : bus.scm_rdata_i[gi]);
`else
    assign rgnt[gi]  = rst_n & bus.rreq_i[gi] & ~hazard;
    assign re[gi]    = rgnt[gi];
    assign rdata[gi] = rgnt[gi] ? bus.scm_rdata_i[gi] : '0;
`endif
    assign bus.scm_raddr_o[gi] = bus.raddr_i[gi];
  end

  assign bus.wgnt_o      = gnt_vec;
  assign bus.scm_we_o    = we;
  assign bus.scm_waddr_o = waddr;
  assign bus.scm_wdata_o = wdata;
  assign bus.rgnt_o      = rgnt;
  assign bus.scm_re_o    = re;
  assign bus.rdata_o     = rdata;
  assign bus.busy_o      = infl_valid_q;
endmodule

// File: tb/tb_scm_write_arbiter.sv
// Randomized scoreboard bench for scm_write_arbiter with a behavioural SCM.
module tb_scm_write_arbiter;
  localparam int NW = 4;
  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NWORDS = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scm_write_arbiter_if #(.N_WRITE(NW), .N_READ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  scm_write_arbiter #(.N_WRITE(NW), .N_READ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  // ---------------- behavioural latch SCM ----------------
  // A sampled write is committed one edge later; during that cycle the
  // transparent latch yields garbage for the address being written.
  logic [DW-1:0]     mem [NWORDS];
  logic [NWORDS-1:0] wr_v = '0;
  logic              pend_v = 1'b0;
  logic [AW-1:0]     pend_a = '0;
  logic [DW-1:0]     pend_d = '0;

  always @(posedge clk) begin
    if (pend_v) begin
      mem[pend_a]  <= pend_d;
      wr_v[pend_a] <= 1'b1;
    end
    pend_v <= bus.scm_we_o;
    pend_a <= bus.scm_waddr_o;
    pend_d <= bus.scm_wdata_o;
  end

  always_comb begin
    bus.scm_rdata_i = '0;
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      a = bus.scm_raddr_o[i];
      v = wr_v[a] ? mem[a] : init_val(int'(a));
      if (pend_v && pend_a == a) v = ~v;
      bus.scm_rdata_i[i] = v;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int                    cyc;
    bit                    rst;
    logic [NW-1:0]         wgnt;
    logic                  we;
    logic [AW-1:0]         wa;
    logic [DW-1:0]         wd;
    logic [NR-1:0]         rgnt;
    logic [NR-1:0]         re;
    logic [NR-1:0][AW-1:0] ra;
    logic [NR-1:0][DW-1:0] rd;
    logic                  busy;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;

  logic [DW-1:0] ref_mem [NWORDS];
  int            ref_ptr = 0;
  bit            ref_busy = 0;
  logic [AW-1:0] ref_iaddr = '0;
  logic [DW-1:0] ref_idata = '0;

  logic [NW-1:0]         w_req = '0;
  logic [NW-1:0][AW-1:0] w_addr = '0;
  logic [NW-1:0][DW-1:0] w_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One clock cycle: apply inputs, predict outputs, advance the model.
  task automatic cycle(input bit rst_in, input logic [NR-1:0] rr,
                       input logic [NR-1:0][AW-1:0] ra, output int g);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = ~rst_in;
    bus.wreq_i  = w_req;
    bus.waddr_i = w_addr;
    bus.wdata_i = w_data;
    bus.rreq_i  = rr;
    bus.raddr_i = ra;

    if (rst_in) begin
      ref_ptr  = 0;
      ref_busy = 0;
    end
    g = -1;
    if (!rst_in) begin
      for (int k = 0; k < NW; k++) begin
        int idx;
        idx = (ref_ptr + k) % NW;
        if (g < 0 && w_req[idx]) g = idx;
      end
    end

    e.cyc  = cyc_no;
    e.rst  = rst_in;
    e.wgnt = '0;
    e.we   = 1'b0;
    e.wa   = '0;
    e.wd   = '0;
    if (g >= 0) begin
      e.wgnt[g] = 1'b1;
      e.we      = 1'b1;
      e.wa      = w_addr[g];
      e.wd      = w_data[g];
    end
    e.busy = ref_busy;
    e.ra   = ra;
    e.rgnt = '0;
    e.re   = '0;
    e.rd   = '0;
    for (int i = 0; i < NR; i++) begin
      if (rr[i] && !rst_in) begin
        if (ref_busy && ra[i] == ref_iaddr) begin
`ifdef SCM_WARB_BYPASS_EN
          e.rgnt[i] = 1'b1;
          e.rd[i]   = ref_idata;
`endif
        end else begin
          e.rgnt[i] = 1'b1;
          e.re[i]   = 1'b1;
          e.rd[i]   = ref_mem[ra[i]];
        end
      end
    end
    exp_q.push_back(e);
    cyc_no++;

    if (g >= 0) begin
      ref_ptr          = (g + 1) % NW;
      ref_busy         = 1;
      ref_iaddr        = w_addr[g];
      ref_idata        = w_data[g];
      ref_mem[w_addr[g]] = w_data[g];
    end else begin
      ref_busy = 0;
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("cyc %0d rst=%0d wgnt=%b we=%b rgnt=%b busy=%b", e.cyc, e.rst,
               bus.wgnt_o, bus.scm_we_o, bus.rgnt_o, bus.busy_o);
      check($sformatf("c%0d wgnt", e.cyc), 64'(bus.wgnt_o), 64'(e.wgnt));
      check($sformatf("c%0d scm_we", e.cyc), 64'(bus.scm_we_o), 64'(e.we));
      check($sformatf("c%0d scm_waddr", e.cyc), 64'(bus.scm_waddr_o), 64'(e.wa));
      check($sformatf("c%0d scm_wdata", e.cyc), 64'(bus.scm_wdata_o), 64'(e.wd));
      check($sformatf("c%0d busy", e.cyc), 64'(bus.busy_o), 64'(e.busy));
      check($sformatf("c%0d rgnt", e.cyc), 64'(bus.rgnt_o), 64'(e.rgnt));
      check($sformatf("c%0d scm_re", e.cyc), 64'(bus.scm_re_o), 64'(e.re));
      if (!e.rst) begin
        for (int i = 0; i < NR; i++) begin
          check($sformatf("c%0d scm_raddr%0d", e.cyc, i), 64'(bus.scm_raddr_o[i]), 64'(e.ra[i]));
          check($sformatf("c%0d rdata%0d", e.cyc, i), 64'(bus.rdata_o[i]), 64'(e.rd[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NR-1:0][AW-1:0] ra;
    int g;
    for (int a = 0; a < NWORDS; a++) ref_mem[a] = init_val(a);
    bus.wreq_i = '0; bus.waddr_i = '0; bus.wdata_i = '0;
    bus.rreq_i = '0; bus.raddr_i = '0;
    ra = '0;

    // reset, then idle
    cycle(1, 2'b00, ra, g);
    cycle(1, 2'b00, ra, g);
    cycle(0, 2'b00, ra, g);
    cycle(0, 2'b00, ra, g);

    // all requesting: 0,1,2,3,0
    for (int k = 0; k < NW; k++) begin
      w_addr[k] = AW'(16 + k);
      w_data[k] = 32'h1111_0000 + DW'(k);
    end
    w_req = 4'b1111;
    for (int n = 0; n < 5; n++) cycle(0, 2'b00, ra, g);

    // move pointer to 2, then 1010 -> 3,1,3
    w_req = 4'b0010;
    cycle(0, 2'b00, ra, g);
    w_req = 4'b1010;
    for (int n = 0; n < 3; n++) cycle(0, 2'b00, ra, g);

    // write 5 in T, read 5 in T+1 and T+2
    w_req = 4'b0001; w_addr[0] = 5'd5; w_data[0] = 32'hA5A5_A5A5;
    cycle(0, 2'b00, ra, g);
    w_req = '0; ra[0] = 5'd5;
    cycle(0, 2'b01, ra, g);
    cycle(0, 2'b01, ra, g);

    // same-cycle read of the written address returns the old value
    w_req = 4'b0001; w_data[0] = 32'h5A5A_5A5A; ra[1] = 5'd5;
    cycle(0, 2'b10, ra, g);
    w_req = '0; ra[0] = 5'd6;
    cycle(0, 2'b01, ra, g);
    cycle(0, 2'b00, ra, g);

    // reset in the cycle after a grant
    w_req = 4'b0001; w_data[0] = 32'h1234_5678;
    cycle(0, 2'b00, ra, g);
    w_req = 4'b1111; ra[0] = 5'd5;
    cycle(1, 2'b01, ra, g);
    cycle(0, 2'b01, ra, g);
    w_req = '0;
    cycle(0, 2'b00, ra, g);

    // randomized traffic over a small address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [NR-1:0] rr;
      bit rst_in;
      for (int k = 0; k < NW; k++) begin
        if (!w_req[k]) begin
          if ($urandom_range(0, 99) < 40) begin
            w_req[k]  = 1'b1;
            w_addr[k] = AW'($urandom_range(0, 7));
            w_data[k] = $urandom;
          end
        end else if ($urandom_range(0, 99) < 5) begin
          w_req[k] = 1'b0;
        end
      end
      rr = NR'($urandom);
      for (int i = 0; i < NR; i++)
        ra[i] = ($urandom_range(0, 1) == 1) ? ref_iaddr : AW'($urandom_range(0, 7));
      rst_in = ($urandom_range(0, 99) == 0);
      cycle(rst_in, rr, ra, g);
      if (g >= 0) w_req[g] = 1'b0;
    end

    w_req = '0;
    cycle(0, 2'b00, ra, g);
    @(negedge clk);
    @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
